// File: rtl/regfile_pkg.sv
// Shared types and helpers for the byte-enable CSR block: index widths,
// byte-enable width derivation and the decoded access record.
package regfile_pkg;

  localparam int unsigned CTRL_IDX_W = 8;
  localparam int unsigned STAT_IDX_W = 8;
  // Wide enough for either bank; ADDR_W must not exceed this.
  localparam int unsigned IDX_W = (CTRL_IDX_W > STAT_IDX_W) ? CTRL_IDX_W : STAT_IDX_W;

  function automatic int unsigned be_width(input int unsigned dw);
    return (dw + 7) / 8;
  endfunction

  typedef struct packed {
    logic             status_sel;
    logic             in_range;
    logic [IDX_W-1:0] idx;
  } rf_access_t;

endpackage

// File: rtl/regfile_rd_pipe.sv
// RD_LAT-deep read-return pipe; data at each stage only moves with a valid,
// so the output holds the last returned word while idle.
module regfile_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  always_comb begin
    vld_d[0] = vld_i;
    dat_d[0] = vld_i ? dat_i : dat_q[0];
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q[RD_LAT-1];
  assign dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/regfile_pipe_be.sv
// CSR block: byte-enable control regs (optional pulse), status regs (optional
// sticky W1C) and a pipelined read port. Define REGFILE_IRQ_EN for irq_o.
module regfile_pipe_be
  import regfile_pkg::*;
#(
  parameter int unsigned          STAT_CNT         = 32,
  parameter int unsigned          CTRL_CNT         = 32,
  parameter int unsigned          ADDR_W           = 7,
  parameter int unsigned          DATA_W           = 32,
  parameter int unsigned          BE_W             = be_width(DATA_W),
  parameter bit                   SEL_SR_BY_MSB    = 1'b1,
  parameter int unsigned          RD_LAT           = 1,
  parameter logic [CTRL_CNT-1:0]  CTRL_PULSE_MASK  = '0,
  parameter logic [STAT_CNT-1:0]  STAT_STICKY_MASK = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wren_i,
  input  logic              rden_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] sreg_i [STAT_CNT],
  output logic [DATA_W-1:0] data_o,
  output logic              rdvalid_o,
  output logic [DATA_W-1:0] creg_o [CTRL_CNT],
  output logic              irq_o
);

  localparam logic [IDX_W-1:0] CTRL_CNT_L = IDX_W'(CTRL_CNT);
  localparam logic [IDX_W-1:0] STAT_CNT_L = IDX_W'(STAT_CNT);

  rf_access_t        acc;
  logic [IDX_W-1:0]  addr_ext;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] ctrl_q [CTRL_CNT];
  logic [DATA_W-1:0] ctrl_d [CTRL_CNT];
  logic [DATA_W-1:0] stat_q [STAT_CNT];
  logic [DATA_W-1:0] stat_d [STAT_CNT];

  always_comb begin
    addr_ext = IDX_W'(addr_i);
    acc      = '0;
    if (SEL_SR_BY_MSB) begin
      acc.status_sel = addr_i[ADDR_W-1];
      acc.idx        = IDX_W'(addr_i[ADDR_W-2:0]);
    end else begin
      acc.status_sel = (addr_ext >= CTRL_CNT_L);
      acc.idx        = acc.status_sel ? (addr_ext - CTRL_CNT_L) : addr_ext;
    end
    acc.in_range = acc.status_sel ? (acc.idx < STAT_CNT_L) : (acc.idx < CTRL_CNT_L);
  end

  // Top lane may be partial: bits past DATA_W simply do not exist.
  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < DATA_W; b++) wmask[b] = be_i[b/8];
  end

  always_comb begin
    for (int unsigned k = 0; k < CTRL_CNT; k++) begin
      ctrl_d[k] = CTRL_PULSE_MASK[k] ? '0 : ctrl_q[k];
      if (wren_i && !acc.status_sel && acc.in_range && acc.idx == IDX_W'(k))
        ctrl_d[k] = (ctrl_d[k] & ~wmask) | (data_i & wmask);
    end
    // Set is OR-ed after the clear so a coincident event survives.
    for (int unsigned k = 0; k < STAT_CNT; k++) begin
      stat_d[k] = '0;
      if (STAT_STICKY_MASK[k]) begin
        stat_d[k] = stat_q[k];
        if (wren_i && acc.status_sel && acc.in_range && acc.idx == IDX_W'(k))
          stat_d[k] = stat_q[k] & ~(data_i & wmask);
        stat_d[k] = stat_d[k] | sreg_i[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (acc.in_range) begin
      for (int unsigned k = 0; k < CTRL_CNT; k++)
        if (!acc.status_sel && acc.idx == IDX_W'(k) && !CTRL_PULSE_MASK[k])
          rdata = ctrl_q[k];
      for (int unsigned k = 0; k < STAT_CNT; k++)
        if (acc.status_sel && acc.idx == IDX_W'(k))
          rdata = STAT_STICKY_MASK[k] ? stat_q[k] : sreg_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < CTRL_CNT; k++) ctrl_q[k] <= '0;
      for (int unsigned k = 0; k < STAT_CNT; k++) stat_q[k] <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      stat_q <= stat_d;
    end
  end

  assign creg_o = ctrl_q;

`ifdef REGFILE_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int unsigned k = 0; k < STAT_CNT; k++) irq_d = irq_d | (|stat_q[k]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  regfile_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .vld_i   (rden_i),
    .dat_i   (rdata),
    .vld_o   (rdvalid_o),
    .dat_o   (data_o)
  );

endmodule
